// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a MEM-stage master and data_memory_ctrl.
// Parameters must match the controller's DATAPATH_WIDTH / ADDRESS_WIDTH.
interface data_memory_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Pipelined byte/half/word data memory controller with fixed-latency responses.
// Optional DMEM_STATS_EN adds saturating load/store/error counters.
module data_memory_ctrl #(
    parameter int DATAPATH_WIDTH = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int MEM_WORDS      = 1024,
    parameter int READ_LATENCY   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    data_memory_ctrl_if.slave  bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]        stat_loads,
    output logic [15:0]        stat_stores,
    output logic [15:0]        stat_errors
`endif
);
    localparam int         IDX_W   = $clog2(MEM_WORDS);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [DATAPATH_WIDTH-1:0] r_mem [MEM_WORDS];
    logic                      r_req_ready;
    logic [READ_LATENCY-1:0]   r_pipe_valid;
    logic [READ_LATENCY-1:0]   r_pipe_error;
    logic [DATAPATH_WIDTH-1:0] r_pipe_rdata [READ_LATENCY];

    logic                      w_accept;
    logic [ADDRESS_WIDTH-3:0]  w_word_idx;
    logic [IDX_W-1:0]          w_mem_idx;
    logic [1:0]                w_lane;
    logic [4:0]                w_shamt;
    logic                      w_error;
    logic [3:0]                w_be;
    logic [DATAPATH_WIDTH-1:0] w_wdata_sh;
    logic [DATAPATH_WIDTH-1:0] w_rd_word;
    logic [DATAPATH_WIDTH-1:0] w_rd_sh;
    logic [DATAPATH_WIDTH-1:0] w_load_data;
    logic [DATAPATH_WIDTH-1:0] w_rsp_data;

    assign w_accept   = bus.req_valid && r_req_ready;
    assign w_word_idx = bus.req_addr[ADDRESS_WIDTH-1:2];
    assign w_mem_idx  = w_word_idx[IDX_W-1:0];
    assign w_lane     = bus.req_addr[1:0];
    assign w_shamt    = {w_lane, 3'b000};

    always_comb begin
        w_error = 1'b0;
        case (bus.req_size)
            SZ_BYTE: w_error = 1'b0;
            SZ_HALF: w_error = w_lane[0];
            SZ_WORD: w_error = (w_lane != 2'b00);
            default: w_error = 1'b1;
        endcase
        // MEM_WORDS is a power of two, so any index bit above IDX_W means out of range
        if ((w_word_idx >> IDX_W) != '0) begin
            w_error = 1'b1;
        end
    end

    always_comb begin
        w_be = 4'b0000;
        case (bus.req_size)
            SZ_BYTE: w_be = 4'b0001 << w_lane;
            SZ_HALF: w_be = 4'b0011 << w_lane;
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_wdata_sh = bus.req_wdata << w_shamt;
    assign w_rd_word  = r_mem[w_mem_idx];
    assign w_rd_sh    = w_rd_word >> w_shamt;

    always_comb begin
        w_load_data = w_rd_sh;
        case (bus.req_size)
            SZ_BYTE: w_load_data = bus.req_unsigned
                ? {{(DATAPATH_WIDTH-8){1'b0}}, w_rd_sh[7:0]}
                : {{(DATAPATH_WIDTH-8){w_rd_sh[7]}}, w_rd_sh[7:0]};
            SZ_HALF: w_load_data = bus.req_unsigned
                ? {{(DATAPATH_WIDTH-16){1'b0}}, w_rd_sh[15:0]}
                : {{(DATAPATH_WIDTH-16){w_rd_sh[15]}}, w_rd_sh[15:0]};
            default: w_load_data = w_rd_sh;
        endcase
    end

    assign w_rsp_data = (bus.req_write || w_error) ? '0 : w_load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b0;
        end else begin
            r_req_ready <= 1'b1;
        end
    end

    // r_req_ready is cleared asynchronously, so no write can land during reset
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_write && !w_error) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_valid <= '0;
            r_pipe_error <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_rdata[i] <= '0;
            end
        end else begin
            r_pipe_valid[0] <= w_accept;
            r_pipe_error[0] <= w_accept && w_error;
            r_pipe_rdata[0] <= w_accept ? w_rsp_data : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_error[i] <= r_pipe_error[i-1];
                r_pipe_rdata[i] <= r_pipe_rdata[i-1];
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_pipe_valid[READ_LATENCY-1];
    assign bus.rsp_error = r_pipe_error[READ_LATENCY-1];
    assign bus.rsp_rdata = r_pipe_rdata[READ_LATENCY-1];

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errors <= '0;
        end else if (w_accept) begin
            if (w_error) begin
                if (stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
            end else if (bus.req_write) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl (READ_LATENCY=3): responses are captured
// on the falling edge and compared in order against hand-computed expectations.
module tb_data_memory_ctrl;
    localparam int LAT = 3;

    typedef struct {
        int          c;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ncyc;
    int   n_ld;
    int   n_st;
    int   n_err;
    rsp_t act[$];
    rsp_t exp_q[$];

    data_memory_ctrl_if #(.DW(32), .AW(32)) bus ();

`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads;
    logic [15:0] stat_stores;
    logic [15:0] stat_errors;
`endif

    data_memory_ctrl #(
        .DATAPATH_WIDTH(32),
        .ADDRESS_WIDTH (32),
        .MEM_WORDS     (1024),
        .READ_LATENCY  (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef DMEM_STATS_EN
        ,
        .stat_loads (stat_loads),
        .stat_stores(stat_stores),
        .stat_errors(stat_errors)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (bus.rsp_valid) begin
            act.push_back('{ncyc, bus.rsp_rdata, bus.rsp_error});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; leaves the bus idle just after the accept edge.
    task automatic send(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        exp_q.push_back('{ncyc + LAT, ed, ee});
        if (ee) n_err++;
        else if (w) n_st++;
        else n_ld++;
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (act.size() < exp_q.size() && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (LAT + 2) @(negedge clk);
        chk($sformatf("%s.count", tag), act.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act.size()) begin
                chk($sformatf("%s[%0d].data", tag, i), act[i].d, exp_q[i].d);
                chk($sformatf("%s[%0d].error", tag, i), {31'b0, act[i].e}, {31'b0, exp_q[i].e});
                chk($sformatf("%s[%0d].cycle", tag, i), act[i].c, exp_q[i].c);
            end
        end
        act.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0; ncyc = 0;
        n_ld = 0; n_st = 0; n_err = 0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.req_ready", bus.req_ready, 0);
        chk("reset.rsp_valid", bus.rsp_valid, 0);
        chk("reset.rsp_rdata", bus.rsp_rdata, 0);
        chk("reset.rsp_error", bus.rsp_error, 0);
        rst_n = 1'b1;
        #1;
        chk("release.ready_before_edge", bus.req_ready, 0);
        @(posedge clk);
        #1;
        chk("release.ready_after_edge", bus.req_ready, 1);

        // word stores then word loads
        send(1, 2'b10, 0, 32'h0, 32'h8,    32'h0,        0);
        send(1, 2'b10, 0, 32'h4, 32'h1234, 32'h0,        0);
        send(0, 2'b10, 0, 32'h0, 32'h0,    32'h00000008, 0);
        send(0, 2'b10, 0, 32'h4, 32'h0,    32'h00001234, 0);
        drain("word");

        // byte/half lanes, extension and misalignment
        send(1, 2'b10, 0, 32'h8,  32'h11223344, 32'h0,        0);
        send(1, 2'b00, 0, 32'h9,  32'h000000A5, 32'h0,        0);
        send(0, 2'b10, 0, 32'h8,  32'h0,        32'h1122A544, 0);
        send(0, 2'b00, 0, 32'h9,  32'h0,        32'hFFFFFFA5, 0);
        send(0, 2'b00, 1, 32'h9,  32'h0,        32'h000000A5, 0);
        send(0, 2'b01, 0, 32'hA,  32'h0,        32'h00001122, 0);
        send(0, 2'b01, 0, 32'h8,  32'h0,        32'hFFFFA544, 0);
        send(0, 2'b01, 1, 32'h8,  32'h0,        32'h0000A544, 0);
        send(0, 2'b01, 0, 32'h9,  32'h0,        32'h0,        1);
        send(1, 2'b01, 0, 32'h9,  32'h0000FFFF, 32'h0,        1);
        send(0, 2'b10, 0, 32'h8,  32'h0,        32'h1122A544, 0);
        send(1, 2'b01, 0, 32'h2,  32'h1234BEEF, 32'h0,        0);
        send(0, 2'b10, 0, 32'h0,  32'h0,        32'hBEEF0008, 0);
        send(0, 2'b00, 0, 32'h3,  32'h0,        32'hFFFFFFBE, 0);
        drain("lanes");

        // back-to-back loads, consecutive responses
        send(0, 2'b10, 0, 32'h0, 32'h0, 32'hBEEF0008, 0);
        send(0, 2'b10, 0, 32'h4, 32'h0, 32'h00001234, 0);
        send(0, 2'b10, 0, 32'h8, 32'h0, 32'h1122A544, 0);
        drain("b2b");

        // range and reserved-size errors, last legal word
        send(1, 2'b10, 0, 32'h1000, 32'hDEADBEEF, 32'h0,        1);
        send(0, 2'b11, 0, 32'h0,    32'h0,        32'h0,        1);
        send(0, 2'b10, 0, 32'h2,    32'h0,        32'h0,        1);
        send(0, 2'b00, 0, 32'h1003, 32'h0,        32'h0,        1);
        send(1, 2'b10, 0, 32'hFFC,  32'hCAFEF00D, 32'h0,        0);
        send(0, 2'b10, 0, 32'hFFC,  32'h0,        32'hCAFEF00D, 0);
        send(0, 2'b10, 0, 32'h0,    32'h0,        32'hBEEF0008, 0);
        drain("range");

`ifdef DMEM_STATS_EN
        chk("stats.loads",  {16'b0, stat_loads},  n_ld);
        chk("stats.stores", {16'b0, stat_stores}, n_st);
        chk("stats.errors", {16'b0, stat_errors}, n_err);
`endif

        // reset while loads are in flight
        send(0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 0);
        send(0, 2'b10, 0, 32'h4, 32'h0, 32'h0, 0);
        send(0, 2'b10, 0, 32'h8, 32'h0, 32'h0, 0);
        chk("inflight.rsp_visible", bus.rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset.rsp_valid", bus.rsp_valid, 0);
        chk("midreset.req_ready", bus.req_ready, 0);
`ifdef DMEM_STATS_EN
        chk("midreset.stat_loads",  {16'b0, stat_loads},  0);
        chk("midreset.stat_stores", {16'b0, stat_stores}, 0);
        chk("midreset.stat_errors", {16'b0, stat_errors}, 0);
`endif
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rerelease.ready_before_edge", bus.req_ready, 0);
        @(posedge clk);
        #1;
        chk("rerelease.ready_after_edge", bus.req_ready, 1);
        repeat (LAT + 5) @(negedge clk);
        chk("rerelease.no_stale_rsp", act.size(), 0);
        act.delete();
        @(posedge clk);
        #1;

        // stores committed before reset survive it
        send(0, 2'b10, 0, 32'h4, 32'h0, 32'h00001234, 0);
        drain("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish, observed time limit expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the single-port word data memory used in the MEM stage.
- Adds a valid/ready request interface with byte, half and word load/store sizes.
- Loads are sign- or zero-extended; stores write only the addressed byte lanes.
- Read latency is configurable and pipelined, with alignment and range error reporting.

Parameters:
- DATAPATH_WIDTH, 32: data width in bits; fixed at 32 for this generation.
- ADDRESS_WIDTH, 32: byte address width.
- MEM_WORDS, 1024: number of 32-bit words in the array (power of two).
- READ_LATENCY, 1: cycles from accepted request to rsp_valid; legal range 1..4.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATAPATH_WIDTH  store data, right-justified.
- rsp_valid  out  1  response present for exactly one cycle.
- rsp_rdata  out  DATAPATH_WIDTH  extended load data; 0 for stores and errors.
- rsp_error  out  1  request was misaligned, out of range or reserved size.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0; all pipeline stages cleared.
- Array contents are not reset.
- Accept: a request is accepted when req_valid && req_ready at a rising edge.
- req_ready is registered. It rises on the first clock edge after rst_n deasserts and then stays 1; there is no backpressure.
- Throughput: one request per cycle, fully pipelined. Responses return in request order.
- Latency: rsp_valid is high exactly READ_LATENCY cycles after the accept edge, for every request including stores and errors. Stores are write acknowledges.
- Decode:
  - word index = req_addr[ADDRESS_WIDTH-1:2]
  - lane = req_addr[1:0]
- Error conditions, checked in this order of definition:
  - req_size=11 (reserved size)
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - word index >= MEM_WORDS
- On error: no array write, rsp_rdata=0, rsp_error=1.
- Store lane selection:
  - byte: writes lane addr[1:0] with req_wdata[7:0].
  - half: writes lanes {addr[1],0} and {addr[1],1} with req_wdata[15:0], little-endian.
  - word: writes all four lanes.
  - Unselected lanes are unchanged.
  - The write commits at the accept edge.
- Load extraction:
  - The selected lanes are shifted to bit 0.
  - Sign-extended from bit 7 (byte) or bit 15 (half), unless req_unsigned=1.
  - Word loads ignore req_unsigned.
- Ordering: a load accepted on the cycle after a store to the same word returns the stored data; the array is written before the next read samples it.
- Reset mid-operation: asserting rst_n immediately clears req_ready, rsp_valid and all in-flight responses; in-flight loads are dropped.
- A store whose accept edge occurred before reset assertion remains committed.
- No write occurs while rst_n=0.
- The first request after release must wait for req_ready=1.

Optional Feature:
- Macro: DMEM_STATS_EN.
- When defined, three outputs are added:
  - stat_loads [15:0]: counts accepted error-free loads.
  - stat_stores [15:0]: counts accepted error-free stores.
  - stat_errors [15:0]: counts accepted requests with errors.
- Each counter increments at the accept edge, saturates at 16'hFFFF and resets to 0 on rst_n.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Word store 32'h8 to addr 0, then word store 32'h1234 to addr 4, then word loads of addr 0 and 4 -> rsp_rdata 32'h00000008 then 32'h00001234, rsp_error=0, each READ_LATENCY cycles after accept.
- Word store 32'h11223344 to addr 8, then byte store 8'hA5 to addr 9 -> word load of addr 8 returns 32'h1122A544. Signed byte load of addr 9 returns 32'hFFFFFFA5; unsigned byte load returns 32'h000000A5.
- Half load of addr 10 after the above -> signed 32'h00001122. Half load of addr 9 -> rsp_error=1, rsp_rdata=0, and the memory is unchanged.
- With READ_LATENCY=3, issue back-to-back loads of addr 0, 4, 8 on consecutive cycles -> three consecutive rsp_valid cycles in order, the first 3 cycles after the first accept.
- Store to word index MEM_WORDS (addr 4*1024 = 32'h1000) and a request with req_size=11 -> rsp_error=1 for both, and a word load of addr 0 is unaffected.
- Assert rst_n low while two loads are in flight -> rsp_valid=0 immediately, no response is emitted for them after release, and req_ready returns to 1 one edge after release. With DMEM_STATS_EN, the counters read 0.
